// File: rtl/piece_move_scanner.sv
// Sequential pseudo-legal move generator for one square on a ROWS x COLS board.
// Reads one square per cycle; done pulses 2 + attempts cycles after start.
module piece_move_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS),
  parameter int NSQ  = ROWS * COLS,
  parameter int CNTW = $clog2(NSQ + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [RW-1:0]   src_row,
  input  logic [CW-1:0]   src_col,
  output logic [RW-1:0]   rd_row,
  output logic [CW-1:0]   rd_col,
  input  logic [4:0]      rd_piece,
  output logic            busy,
  output logic            done,
  output logic            err_empty,
  output logic [NSQ-1:0]  move_mask,
  output logic [CNTW-1:0] move_count
);

  localparam int IW = $clog2(NSQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SRC  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] T_PAWN   = 3'd1;
  localparam logic [2:0] T_KNIGHT = 3'd2;
  localparam logic [2:0] T_BISHOP = 3'd3;
  localparam logic [2:0] T_ROOK   = 3'd4;
  localparam logic [2:0] T_QUEEN  = 3'd5;

  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   src_row_q, src_row_d;
  logic [CW-1:0]   src_col_q, src_col_d;
  logic [RW-1:0]   pos_row_q, pos_row_d;
  logic [CW-1:0]   pos_col_q, pos_col_d;
  logic            colour_q, colour_d;
  logic [2:0]      type_q, type_d;
  logic [2:0]      dir_q, dir_d;
  logic            fwd1_q, fwd1_d;
  logic [NSQ-1:0]  mask_q, mask_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic signed [2:0]    dr, dc;
  logic signed [RW+1:0] cand_row;
  logic signed [CW+1:0] cand_col;
  logic                 on_board;
  logic [IW-1:0]        sq_idx;
  logic                 pc_valid, tgt_empty, tgt_opp;
  logic                 sliding, last_dir, start_row;
  logic [2:0]           stride;
  logic                 take, adv;

  // Direction table: sliders and king share the N..NW ring; rook/bishop stride over it.
  always_comb begin
    dr = 3'sd0;
    dc = 3'sd0;
    case (type_q)
      T_PAWN: begin
        dr = colour_q ? 3'sd1 : -3'sd1;
        case (dir_q[1:0])
          2'd1:    dr = colour_q ? 3'sd2 : -3'sd2;
          2'd2:    dc = -3'sd1;
          2'd3:    dc = 3'sd1;
          default: dc = 3'sd0;
        endcase
      end
      T_KNIGHT: begin
        case (dir_q)
          3'd0:    begin dr = -3'sd2; dc = -3'sd1; end
          3'd1:    begin dr = -3'sd2; dc = 3'sd1;  end
          3'd2:    begin dr = -3'sd1; dc = -3'sd2; end
          3'd3:    begin dr = -3'sd1; dc = 3'sd2;  end
          3'd4:    begin dr = 3'sd1;  dc = -3'sd2; end
          3'd5:    begin dr = 3'sd1;  dc = 3'sd2;  end
          3'd6:    begin dr = 3'sd2;  dc = -3'sd1; end
          default: begin dr = 3'sd2;  dc = 3'sd1;  end
        endcase
      end
      default: begin
        case (dir_q)
          3'd0:    begin dr = -3'sd1; dc = 3'sd0;  end
          3'd1:    begin dr = -3'sd1; dc = 3'sd1;  end
          3'd2:    begin dr = 3'sd0;  dc = 3'sd1;  end
          3'd3:    begin dr = 3'sd1;  dc = 3'sd1;  end
          3'd4:    begin dr = 3'sd1;  dc = 3'sd0;  end
          3'd5:    begin dr = 3'sd1;  dc = -3'sd1; end
          3'd6:    begin dr = 3'sd0;  dc = -3'sd1; end
          default: begin dr = -3'sd1; dc = -3'sd1; end
        endcase
      end
    endcase
  end

  always_comb begin
    cand_row = $signed({2'b00, pos_row_q}) + (RW+2)'(dr);
    cand_col = $signed({2'b00, pos_col_q}) + (CW+2)'(dc);
    on_board = !cand_row[RW+1] && (cand_row < $signed((RW+2)'(ROWS))) &&
               !cand_col[CW+1] && (cand_col < $signed((CW+2)'(COLS)));
    sq_idx   = IW'(cand_row[RW-1:0]) * IW'(COLS) + IW'(cand_col[CW-1:0]);
  end

  always_comb begin
    pc_valid  = rd_piece[0] && (rd_piece[4:2] != 3'd0) && (rd_piece[4:2] != 3'd7);
    tgt_empty = !pc_valid;
    tgt_opp   = pc_valid && (rd_piece[1] != colour_q);
    sliding   = (type_q == T_BISHOP) || (type_q == T_ROOK) || (type_q == T_QUEEN);
    stride    = ((type_q == T_BISHOP) || (type_q == T_ROOK)) ? 3'd2 : 3'd1;
    last_dir  = (type_q == T_PAWN) ? (dir_q == 3'd3) :
                (type_q == T_ROOK) ? (dir_q == 3'd6) : (dir_q == 3'd7);
    start_row = colour_q ? (src_row_q == RW'(1)) : (src_row_q == RW'(ROWS - 2));
  end

  always_comb begin
    rd_row = '0;
    rd_col = '0;
    if (state_q == S_SRC) begin
      rd_row = src_row_q;
      rd_col = src_col_q;
    end else if ((state_q == S_STEP) && on_board) begin
      rd_row = cand_row[RW-1:0];
      rd_col = cand_col[CW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    src_row_d = src_row_q;
    src_col_d = src_col_q;
    pos_row_d = pos_row_q;
    pos_col_d = pos_col_q;
    colour_d  = colour_q;
    type_d    = type_q;
    dir_d     = dir_q;
    fwd1_d    = fwd1_q;
    mask_d    = mask_q;
    count_d   = count_q;
    err_d     = err_q;
    take      = 1'b0;
    adv       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          src_row_d = src_row;
          src_col_d = src_col;
          mask_d    = '0;
          count_d   = '0;
          err_d     = 1'b0;
          state_d   = S_SRC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SRC: begin
        if (!pc_valid) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          colour_d  = rd_piece[1];
          type_d    = rd_piece[4:2];
          dir_d     = (rd_piece[4:2] == T_BISHOP) ? 3'd1 : 3'd0;
          pos_row_d = src_row_q;
          pos_col_d = src_col_q;
          fwd1_d    = 1'b0;
          state_d   = S_STEP;
        end
      end
      S_STEP: begin
        if (!on_board) begin
          adv = 1'b1;
        end else if (type_q == T_PAWN) begin
          adv = 1'b1;
          case (dir_q[1:0])
            2'd0: begin
              take   = tgt_empty;
              fwd1_d = tgt_empty;
            end
            2'd1:    take = start_row && fwd1_q && tgt_empty;
            default: take = tgt_opp;
          endcase
        end else if (tgt_empty) begin
          take = 1'b1;
          if (sliding) begin
            pos_row_d = cand_row[RW-1:0];
            pos_col_d = cand_col[CW-1:0];
          end else begin
            adv = 1'b1;
          end
        end else begin
          take = tgt_opp;
          adv  = 1'b1;
        end
        if (take && !mask_q[sq_idx]) begin
          mask_d[sq_idx] = 1'b1;
          count_d        = count_q + CNTW'(1);
        end
        // A new direction always restarts its ray from the source square.
        if (adv) begin
          pos_row_d = src_row_q;
          pos_col_d = src_col_q;
          if (last_dir) state_d = S_DONE;
          else          dir_d   = dir_q + stride;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_row_q <= '0;
      src_col_q <= '0;
      pos_row_q <= '0;
      pos_col_q <= '0;
      colour_q  <= 1'b0;
      type_q    <= 3'd0;
      dir_q     <= 3'd0;
      fwd1_q    <= 1'b0;
      mask_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_row_q <= src_row_d;
      src_col_q <= src_col_d;
      pos_row_q <= pos_row_d;
      pos_col_q <= pos_col_d;
      colour_q  <= colour_d;
      type_q    <= type_d;
      dir_q     <= dir_d;
      fwd1_q    <= fwd1_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign busy       = (state_q == S_SRC) || (state_q == S_STEP);
  assign done       = (state_q == S_DONE);
  assign err_empty  = err_q;
  assign move_mask  = mask_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_piece_move_scanner.sv
// Directed bench for piece_move_scanner: 8x8 vector table plus 5x5 and reset corner cases.
module tb_piece_move_scanner;

  localparam logic [4:0] WP = 5'b00101, BP = 5'b00111, WN = 5'b01001, BN = 5'b01011;
  localparam logic [4:0] WB = 5'b01101, BB = 5'b01111, WR = 5'b10001, BR = 5'b10011;
  localparam logic [4:0] WQ = 5'b10101, BQ = 5'b10111, WK = 5'b11001, BK = 5'b11011;
  localparam logic [4:0] BAD = 5'b11101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  src_row = '0, src_col = '0;
  logic [2:0]  rd_row, rd_col;
  logic [4:0]  rd_piece;
  logic        busy, done, err_empty;
  logic [63:0] move_mask;
  logic [6:0]  move_count;

  logic        start5 = 1'b0;
  logic [2:0]  src_row5 = '0, src_col5 = '0;
  logic [2:0]  rd_row5, rd_col5;
  logic [4:0]  rd_piece5;
  logic        busy5, done5, err5;
  logic [24:0] mask5;
  logic [4:0]  count5;

  logic [4:0] board  [0:7][0:7];
  logic [4:0] sb     [0:7][0:7];
  logic [4:0] board5 [0:4][0:4];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign rd_piece  = board[rd_row][rd_col];
  assign rd_piece5 = board5[rd_row5][rd_col5];

  piece_move_scanner #(.ROWS(8), .COLS(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .src_row(src_row), .src_col(src_col),
    .rd_row(rd_row), .rd_col(rd_col), .rd_piece(rd_piece), .busy(busy), .done(done),
    .err_empty(err_empty), .move_mask(move_mask), .move_count(move_count)
  );

  piece_move_scanner #(.ROWS(5), .COLS(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5), .src_row(src_row5), .src_col(src_col5),
    .rd_row(rd_row5), .rd_col(rd_col5), .rd_piece(rd_piece5), .busy(busy5), .done(done5),
    .err_empty(err5), .move_mask(mask5), .move_count(count5)
  );

  typedef struct {
    bit          base;
    int          ar, ac;
    logic [4:0]  ap;
    int          br, bc;
    logic [4:0]  bp;
    int          cr, cc;
    logic [4:0]  cp;
    int          sr, sc;
    logic [63:0] mask;
    int          cnt;
    bit          err;
    int          cyc;
  } vec_t;

  function automatic vec_t mkv(bit base, int ar, int ac, logic [4:0] ap,
                               int br, int bc, logic [4:0] bp,
                               int cr, int cc, logic [4:0] cp,
                               int sr, int sc, logic [63:0] mask,
                               int cnt, bit err, int cyc);
    vec_t v;
    v.base = base; v.ar = ar; v.ac = ac; v.ap = ap;
    v.br = br; v.bc = bc; v.bp = bp; v.cr = cr; v.cc = cc; v.cp = cp;
    v.sr = sr; v.sc = sc; v.mask = mask; v.cnt = cnt; v.err = err; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setup(input vec_t v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = v.base ? sb[r][c] : 5'd0;
    if (v.ar >= 0) board[v.ar][v.ac] = v.ap;
    if (v.br >= 0) board[v.br][v.bc] = v.bp;
    if (v.cr >= 0) board[v.cr][v.cc] = v.cp;
  endtask

  // Returns the number of clock edges from the one sampling start up to done.
  task automatic scan(input int r, input int c, input bit pulse_mid, output int cyc);
    @(negedge clk);
    src_row = 3'(r);
    src_col = 3'(c);
    start   = 1'b1;
    cyc     = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = pulse_mid && (cyc == 3 || cyc == 5);
      if (pulse_mid) begin
        src_row = 3'd0;
        src_col = 3'd0;
      end
    end while (!done && cyc < 100);
    start = 1'b0;
  endtask

  vec_t        vecs[12];
  logic [63:0] qm;
  int          qb[27] = '{19, 11, 3, 20, 13, 6, 28, 29, 30, 31, 36, 45, 54, 63,
                          35, 43, 51, 59, 34, 41, 48, 26, 25, 24, 18, 9, 0};

  initial begin
    int cyc;
    int seen;
    logic [4:0] back_b [8];
    logic [4:0] back_w [8];
    back_b = '{BR, BN, BB, BQ, BK, BB, BN, BR};
    back_w = '{WR, WN, WB, WQ, WK, WB, WN, WR};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        sb[r][c] = (r == 0) ? back_b[c] : (r == 1) ? BP :
                   (r == 6) ? WP : (r == 7) ? back_w[c] : 5'd0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        board5[r][c] = 5'd0;
    qm = '0;
    foreach (qb[i]) qm[qb[i]] = 1'b1;

    vecs[0]  = mkv(1, -1, 0, 0, -1, 0, 0, -1, 0, 0, 7, 1,
                   (64'd1 << 40) | (64'd1 << 42), 2, 0, 10);
    vecs[1]  = mkv(1, -1, 0, 0, -1, 0, 0, -1, 0, 0, 6, 4,
                   (64'd1 << 44) | (64'd1 << 36), 2, 0, 6);
    vecs[2]  = mkv(1, 5, 3, BP, -1, 0, 0, -1, 0, 0, 6, 4,
                   (64'd1 << 44) | (64'd1 << 36) | (64'd1 << 43), 3, 0, 6);
    vecs[3]  = mkv(1, 5, 4, WP, -1, 0, 0, -1, 0, 0, 6, 4, 64'd0, 0, 0, 6);
    vecs[4]  = mkv(0, 3, 3, WQ, -1, 0, 0, -1, 0, 0, 3, 3, qm, 27, 0, 37);
    vecs[5]  = mkv(0, 7, 0, WR, 6, 0, WP, 7, 3, BP, 7, 0,
                   (64'd1 << 57) | (64'd1 << 58) | (64'd1 << 59), 3, 0, 8);
    vecs[6]  = mkv(0, -1, 0, 0, -1, 0, 0, -1, 0, 0, 4, 4, 64'd0, 0, 1, 2);
    vecs[7]  = mkv(0, 2, 2, BAD, -1, 0, 0, -1, 0, 0, 2, 2, 64'd0, 0, 1, 2);
    vecs[8]  = mkv(1, -1, 0, 0, -1, 0, 0, -1, 0, 0, 1, 2,
                   (64'd1 << 18) | (64'd1 << 26), 2, 0, 6);
    vecs[9]  = mkv(1, -1, 0, 0, -1, 0, 0, -1, 0, 0, 0, 2, 64'd0, 0, 0, 6);
    vecs[10] = mkv(0, 7, 7, WB, 5, 5, BP, -1, 0, 0, 7, 7,
                   (64'd1 << 54) | (64'd1 << 45), 2, 0, 7);
    vecs[11] = mkv(0, 0, 7, BK, 1, 7, WP, 0, 6, BP, 0, 7,
                   (64'd1 << 14) | (64'd1 << 15), 2, 0, 10);

    setup(vecs[6]);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err_empty), 64'd0);
    chk("reset mask", move_mask, 64'd0);
    chk("reset count", 64'(move_count), 64'd0);
    chk("reset rd", 64'({rd_row, rd_col}), 64'd0);
    chk("reset mask5", 64'(mask5), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      setup(vecs[i]);
      scan(vecs[i].sr, vecs[i].sc, 1'b0, cyc);
      chk($sformatf("v%0d cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      chk($sformatf("v%0d mask", i), move_mask, vecs[i].mask);
      chk($sformatf("v%0d count", i), 64'(move_count), 64'(vecs[i].cnt));
      chk($sformatf("v%0d err", i), 64'(err_empty), 64'(vecs[i].err));
      chk($sformatf("v%0d busy at done", i), 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d mask hold", i), move_mask, vecs[i].mask);
    end

    // start pulses and a changed src while busy must be ignored
    setup(vecs[0]);
    scan(7, 1, 1'b1, cyc);
    chk("busy-start cycles", 64'(cyc), 64'd10);
    chk("busy-start mask", move_mask, (64'd1 << 40) | (64'd1 << 42));
    chk("busy-start count", 64'(move_count), 64'd2);
    @(posedge clk); #1;
    chk("busy-start idle", 64'(busy | done), 64'd0);

    // 5x5 board: king in the corner
    board5[0][0] = WK;
    @(negedge clk);
    src_row5 = 3'd0; src_col5 = 3'd0; start5 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start5 = 1'b0;
    end while (!done5 && cyc < 100);
    chk("king5 cycles", 64'(cyc), 64'd10);
    chk("king5 mask", 64'(mask5), 64'h62);
    chk("king5 count", 64'(count5), 64'd3);
    chk("king5 err", 64'(err5), 64'd0);

    // reset in the middle of a queen scan
    setup(vecs[4]);
    @(negedge clk);
    src_row = 3'd3; src_col = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midscan busy before", 64'(busy), 64'd1);
    chk("midscan mask nonzero", 64'(move_mask != 64'd0), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midscan busy", 64'(busy), 64'd0);
    chk("midscan mask", move_mask, 64'd0);
    chk("midscan count", 64'(move_count), 64'd0);
    seen = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midscan no done", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
